// File: rtl/decoder_pkg.sv
// decoder_pkg: shared select encoding and helpers for the registered 2-to-4 decoder
//   SEL_Y0..SEL_Y3 : select codes for each one-hot output
//   sel_t          : 2-bit select code {i1,i0}
//   idle_level     : 4-bit inactive output pattern for a given polarity
package decoder_pkg;
   localparam logic [1:0] SEL_Y0 = 2'd0;
   localparam logic [1:0] SEL_Y1 = 2'd1;
   localparam logic [1:0] SEL_Y2 = 2'd2;
   localparam logic [1:0] SEL_Y3 = 2'd3;
   typedef logic [1:0] sel_t;
   function automatic logic [3:0] idle_level(input bit active_low);
      return active_low ? 4'hF : 4'h0;
   endfunction
endpackage

// File: rtl/decoder_2x4_core.sv
// decoder_2x4_core: combinational select-to-one-hot map, active-high
//   sel      in  2  select code {i1,i0}
//   en       in  1  decode enable; 0 forces an all-zero vector
//   w_onehot out 4  one-hot vector, bit n active for sel==n
module decoder_2x4_core
   import decoder_pkg::*;
(
   input  sel_t       sel,
   input  logic       en,
   output logic [3:0] w_onehot
);
   always_comb begin
      w_onehot[0] = en && (sel == SEL_Y0);
      w_onehot[1] = en && (sel == SEL_Y1);
      w_onehot[2] = en && (sel == SEL_Y2);
      w_onehot[3] = en && (sel == SEL_Y3);
   end
endmodule

// File: rtl/decoder_2x4.sv
// decoder_2x4: registered 2-to-4 one-hot decoder with selectable output polarity
//   clk   in  1  system clock, rising edge
//   rst   in  1  synchronous active-high reset
//   en    in  1  decode enable
//   i0    in  1  select LSB
//   i1    in  1  select MSB
//   y0..y3 out 1 registered one-hot outputs, inverted when OUT_ACTIVE_LOW=1
//   valid out 1  registered outputs hold a decoded value
module decoder_2x4
   import decoder_pkg::*;
#(
   parameter bit OUT_ACTIVE_LOW = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic i0,
   input  logic i1,
   output logic y0,
   output logic y1,
   output logic y2,
   output logic y3,
   output logic valid
);
   localparam logic [3:0] IDLE = idle_level(OUT_ACTIVE_LOW);
   logic [3:0] w_onehot;
   logic [3:0] r_y;
   logic       r_valid;
   decoder_2x4_core u_core (
      .sel      ({i1, i0}),
      .en       (en),
      .w_onehot (w_onehot)
   );
   // polarity is applied before the register so outputs come straight from flops
   always_ff @(posedge clk) begin
      if (rst) begin
         r_y     <= IDLE;
         r_valid <= 1'b0;
      end else begin
         r_y     <= w_onehot ^ IDLE;
         r_valid <= en;
      end
   end
   assign {y3, y2, y1, y0} = r_y;
   assign valid = r_valid;
endmodule

// File: tb/tb_decoder_2x4.sv
// tb_decoder_2x4: directed and randomized self-checking bench for decoder_2x4
module tb_decoder_2x4;
   logic clk = 1'b0;
   logic rst, en, i0, i1;
   logic a_y0, a_y1, a_y2, a_y3, a_valid;
   logic b_y0, b_y1, b_y2, b_y3, b_valid;
   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   decoder_2x4 #(.OUT_ACTIVE_LOW(1'b0)) u_hi (
      .clk(clk), .rst(rst), .en(en), .i0(i0), .i1(i1),
      .y0(a_y0), .y1(a_y1), .y2(a_y2), .y3(a_y3), .valid(a_valid)
   );
   decoder_2x4 #(.OUT_ACTIVE_LOW(1'b1)) u_lo (
      .clk(clk), .rst(rst), .en(en), .i0(i0), .i1(i1),
      .y0(b_y0), .y1(b_y1), .y2(b_y2), .y3(b_y3), .valid(b_valid)
   );

   function automatic logic [4:0] obs_a();
      return {a_valid, a_y3, a_y2, a_y1, a_y0};
   endfunction
   function automatic logic [4:0] obs_b();
      return {b_valid, b_y3, b_y2, b_y1, b_y0};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic set_in(input logic r, input logic e, input logic s1, input logic s0);
      rst = r;
      en  = e;
      i1  = s1;
      i0  = s0;
   endtask

   initial begin
      logic [4:0] exp_a, exp_b, prev_a;
      logic r, e, s1, s0;
      // 1. reset with en=1, sel=11
      set_in(1, 1, 1, 1);
      step();
      step();
      chk("reset_hi", obs_a(), 5'b0_0000);
      chk("reset_lo", obs_b(), 5'b0_1111);
      // 2. full sweep, (i0,i1) = (0,0),(0,1),(1,0),(1,1)
      set_in(0, 1, 0, 0); step(); chk("sweep_00", obs_a(), 5'b1_0001);
      set_in(0, 1, 1, 0);
      #1 chk("no_comb_path", obs_a(), 5'b1_0001);
      step(); chk("sweep_i1", obs_a(), 5'b1_0100);
      set_in(0, 1, 0, 1); step(); chk("sweep_i0", obs_a(), 5'b1_0010);
      set_in(0, 1, 1, 1); step(); chk("sweep_11", obs_a(), 5'b1_1000);
      chk("sweep_11_lo", obs_b(), 5'b1_0111);
      // 3. enable gating at sel=10
      set_in(0, 1, 1, 0); step(); chk("en_on", obs_a(), 5'b1_0100);
      set_in(0, 0, 1, 0);
      #1 chk("en_off_latency", obs_a(), 5'b1_0100);
      step(); chk("en_off", obs_a(), 5'b0_0000);
      set_in(0, 1, 1, 0); step(); chk("en_on_again", obs_a(), 5'b1_0100);
      // 4. mid-operation reset at sel=11
      set_in(0, 1, 1, 1); step(); chk("mid_pre", obs_a(), 5'b1_1000);
      set_in(1, 1, 1, 1); step(); chk("mid_rst", obs_a(), 5'b0_0000);
      set_in(0, 1, 1, 1); step(); chk("mid_resume", obs_a(), 5'b1_1000);
      // 5. active-low polarity at sel=01
      set_in(0, 1, 0, 1); step(); chk("pol_en", obs_b(), 5'b1_1101);
      set_in(0, 0, 0, 1); step(); chk("pol_dis", obs_b(), 5'b0_1111);
      set_in(1, 1, 0, 1); step(); chk("pol_rst", obs_b(), 5'b0_1111);
      // 6. randomized against a reference model
      prev_a = obs_a();
      for (int k = 0; k < 1000; k++) begin
         r  = ($urandom_range(99) < 5);
         e  = 1'($urandom_range(1));
         s1 = 1'($urandom_range(1));
         s0 = 1'($urandom_range(1));
         set_in(r, e, s1, s0);
         exp_a = 5'b0;
         if (!r && e) exp_a = {1'b1, 4'b0001 << {s1, s0}};
         exp_b = {exp_a[4], ~exp_a[3:0]};
         if (k % 50 == 0) begin
            #1 chk("rnd_hold", obs_a(), prev_a);
         end
         step();
         chk("rnd_hi", obs_a(), exp_a);
         chk("rnd_lo", obs_b(), exp_b);
         chk("rnd_excl", {4'b0, a_valid}, 5'($countones({a_y3, a_y2, a_y1, a_y0})));
         prev_a = obs_a();
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/decoder_2x4.md
Name: decoder_2x4

Overview:
- Registered 2-to-4 one-hot decoder.
- Two select bits i1 (MSB) and i0 (LSB) pick exactly one of four outputs y0..y3.
- Outputs are registered on the single system clock, with one cycle of latency.
- Used as a small address/select decoder wherever a registered one-hot strobe is needed.

Parameters:
- OUT_ACTIVE_LOW, default 0. When 0, the selected output is 1 and the others are 0. When 1, all four outputs are inverted: the selected output is 0 and the others are 1.

Ports:
- clk  input  1  System clock. All state updates on the rising edge.
- rst  input  1  Synchronous, active-high reset, sampled on the rising edge of clk.
- en  input  1  Decode enable. When 0, all outputs go to the inactive level on the next edge.
- i0  input  1  Select bit 0 (LSB).
- i1  input  1  Select bit 1 (MSB).
- y0  output  1  Active when {i1,i0}=00.
- y1  output  1  Active when {i1,i0}=01.
- y2  output  1  Active when {i1,i0}=10.
- y3  output  1  Active when {i1,i0}=11.
- valid  output  1  1 when the registered outputs hold a decoded value, meaning en was 1 at the last edge and reset was not asserted.

Behaviour:
- Select code: sel = {i1,i0}. Mapping: 0→y0, 1→y1, 2→y2, 3→y3.
  - i0=0,i1=1 → y2.
  - i0=1,i1=0 → y1.
- Rising edge with rst=1:
  - y0..y3 take the inactive level (0 when OUT_ACTIVE_LOW=0, 1 otherwise).
  - valid=0.
  - rst takes priority over en and the selects.
- Rising edge with rst=0, en=1:
  - The output for the current sel becomes active and the other three become inactive.
  - valid=1.
- Rising edge with rst=0, en=0: all outputs inactive, valid=0.
- Latency: exactly 1 clock from a change on i0/i1/en to the corresponding change on the outputs. There is no combinational path from inputs to outputs.
- Exclusivity invariant: at every clock edge, either exactly one output is active with valid=1, or none is active with valid=0. The bench checks this after every edge.
- Select changes every cycle: each edge reflects that cycle's sel. No glitch or hold behaviour across cycles.
- Reset mid-operation: the next edge clears the outputs regardless of sel/en. Decoding resumes on the first edge after rst deasserts.
- Before the first reset, output values are undefined. The bench applies reset before checking.

Decomposition:
- Shared package decoder_pkg:
  - Localparams SEL_Y0=2'd0, SEL_Y1=2'd1, SEL_Y2=2'd2, SEL_Y3=2'd3.
  - A 2-bit typedef sel_t.
- One sub-module is natural: decoder_2x4_core. It is purely combinational, maps sel_t plus en to a 4-bit active-high one-hot vector, and has no clock.
- The top module handles polarity inversion via OUT_ACTIVE_LOW and the output/valid registers.

Test Plan:
1. Reset: rst=1 for 2 cycles with en=1, sel=11 → y0..y3=0000, valid=0 (OUT_ACTIVE_LOW=0).
2. Full sweep: rst=0, en=1, apply (i0,i1) = (0,0), (0,1), (1,0), (1,1) on consecutive cycles. One cycle later each, the outputs as y3y2y1y0 are 0001, 0100, 0010, 1000, with valid=1 each cycle.
3. Enable gating: sel=10 with en toggled 1,0,1 → y2=1/valid=1, then all 0/valid=0, then y2=1/valid=1. Each result appears one cycle after the enable change.
4. Mid-operation reset: sel=11 decoding (y3=1), assert rst for one cycle → next edge y0..y3=0000, valid=0. After rst drops, y3=1 again one cycle later.
5. Polarity: OUT_ACTIVE_LOW=1, sel=01, en=1 → y3y2y1y0=1101 and valid=1. With en=0 → 1111 and valid=0. During reset → 1111.
6. Randomized: 1000 cycles of random i0/i1/en/rst (rst 5% probability). Check the exclusivity invariant and 1-cycle latency against a reference model every cycle.
